fsk_symbol_framer: RTL and testbench

Byte-to-symbol framer that sits directly upstream of the 4-FSK modulator/demodulator top level. It accepts bytes over a valid/ready handshake and buffers them in a small FIFO. It emits 2-bit symbols on a fixed symbol grid (one symbol every SYMBOL_CLKS clocks), and it prefixes every burst with a preamble. It also generates the modulator's one-cycle start pulse, so the modulator's `data_in` can be driven straight from `sym_out`.

---
 rtl/fsk_symbol_framer_if.sv | 9 +
 rtl/fsk_symbol_framer.sv | 188 ++++++++++++++++++
 tb/tb_fsk_symbol_framer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsk_symbol_framer_if.sv
// Byte handshake between a byte source and the FSK symbol framer.
interface fsk_symbol_framer_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input byte_ready);
    modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/fsk_symbol_framer.sv
// Byte-to-symbol framer for the 4-FSK modulator: FIFO-buffered bytes go out MSB first as
// 2-bit symbols on a fixed grid, each burst prefixed by an alternating 11/00 preamble.
//   state    | meaning
//   IDLE     | no burst, IDLE_SYM driven, waiting for a byte at a boundary
//   PREAMBLE | sending preamble symbols 0..PREAMBLE_SYMS-1
//   DATA     | sending byte symbols [7:6],[5:4],[3:2],[1:0]
module fsk_symbol_framer #(
    parameter int          SYMBOL_CLKS   = 100,
    parameter int          FIFO_DEPTH    = 4,
    parameter int          PREAMBLE_SYMS = 8,
    parameter logic [1:0]  IDLE_SYM      = 2'b00
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    fsk_symbol_framer_if.slave              s_byte,
    output logic [1:0]                      o_sym_out,
    output logic                            o_sym_strobe,
    output logic                            o_mod_start,
    output logic                            o_busy,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level
);
    localparam int CW = $clog2(SYMBOL_CLKS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_pidx, w_pidx_nxt;
    logic [1:0]      r_didx, w_didx_nxt;
    logic [7:0]      r_byte, w_byte_nxt;
    logic [1:0]      r_sym, w_sym_nxt;
    logic            r_strobe, w_strobe_nxt;
    logic            r_start, w_start_nxt;
    logic            r_busy;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            w_full, w_empty, w_push, w_pop, w_bnd;
    logic [7:0]      w_head;

    function automatic logic [1:0] sym_of(input logic [7:0] b, input logic [1:0] idx);
        logic [1:0] s;
        case (idx)
            2'd0:    s = b[7:6];
            2'd1:    s = b[5:4];
            2'd2:    s = b[3:2];
            default: s = b[1:0];
        endcase
        return s;
    endfunction

    assign w_bnd   = (r_cnt == CW'(SYMBOL_CLKS - 1));
    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_push  = s_byte.byte_valid && s_byte.byte_ready;

    assign s_byte.byte_ready = !w_full && i_reset_n;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (w_bnd) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Storage is not reset; validity is tracked by the pointers and level alone.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_byte.byte_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sym_nxt    = r_sym;
        w_strobe_nxt = 1'b0;
        w_start_nxt  = 1'b0;
        w_pop        = 1'b0;
        w_pidx_nxt   = r_pidx;
        w_didx_nxt   = r_didx;
        w_byte_nxt   = r_byte;
        if (w_bnd) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        w_state_nxt  = S_PREAMBLE;
                        w_pidx_nxt   = '0;
                        w_sym_nxt    = 2'b11;
                        w_strobe_nxt = 1'b1;
                        w_start_nxt  = 1'b1;
                    end
                end
                S_PREAMBLE: begin
                    w_strobe_nxt = 1'b1;
                    if (r_pidx == PW'(PREAMBLE_SYMS - 1)) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_DATA;
                        w_byte_nxt  = w_head;
                        w_didx_nxt  = 2'd0;
                        w_sym_nxt   = w_head[7:6];
                    end else begin
                        w_pidx_nxt = r_pidx + PW'(1);
                        w_sym_nxt  = w_pidx_nxt[0] ? 2'b00 : 2'b11;
                    end
                end
                S_DATA: begin
                    w_strobe_nxt = 1'b1;
                    if (r_didx == 2'd3) begin
                        if (!w_empty) begin
                            w_pop      = 1'b1;
                            w_byte_nxt = w_head;
                            w_didx_nxt = 2'd0;
                            w_sym_nxt  = w_head[7:6];
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_sym_nxt   = IDLE_SYM;
                        end
                    end else begin
                        w_didx_nxt = r_didx + 2'd1;
                        w_sym_nxt  = sym_of(r_byte, w_didx_nxt);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_sym_nxt   = IDLE_SYM;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pidx   <= '0;
            r_didx   <= '0;
            r_byte   <= '0;
            r_sym    <= IDLE_SYM;
            r_strobe <= 1'b0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_pidx   <= w_pidx_nxt;
            r_didx   <= w_didx_nxt;
            r_byte   <= w_byte_nxt;
            r_sym    <= w_sym_nxt;
            r_strobe <= w_strobe_nxt;
            r_start  <= w_start_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_sym_out    = r_sym;
    assign o_sym_strobe = r_strobe;
    assign o_mod_start  = r_start;
    assign o_busy       = r_busy;
    assign o_fifo_level = r_level;
endmodule

// File: tb/tb_fsk_symbol_framer.sv
// Self-checking bench for fsk_symbol_framer: expected symbols are queued as bytes are driven
// and compared on every sym_strobe; multi-cycle corners are hand-written sequences.
module tb_fsk_symbol_framer;
    localparam int SC = 10;
    localparam int PS = 4;
    localparam int FD = 4;

    logic       clk;
    logic       reset_n;
    logic [1:0] sym_out;
    logic       sym_strobe;
    logic       mod_start;
    logic       busy;
    logic [2:0] fifo_level;

    fsk_symbol_framer_if u_if ();

    fsk_symbol_framer #(
        .SYMBOL_CLKS(SC), .FIFO_DEPTH(FD), .PREAMBLE_SYMS(PS), .IDLE_SYM(2'b00)
    ) dut (
        .i_clk(clk), .i_reset_n(reset_n), .s_byte(u_if),
        .o_sym_out(sym_out), .o_sym_strobe(sym_strobe), .o_mod_start(mod_start),
        .o_busy(busy), .o_fifo_level(fifo_level)
    );

    typedef struct {
        logic [1:0] sym;
        logic       busy;
        logic       start;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic [7:0] s;
    } vec_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   tb_cnt = 0;
    logic rst_edge = 1'b0;
    int   n_strobe = 0;
    int   n_start = 0;
    int   t_start = 0;
    int   last_strobe_cyc = 0;
    logic prev_strobe_busy = 1'b0;
    logic [1:0] prev_sym = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_edge <= !reset_n;
        if (!reset_n || tb_cnt == SC - 1) tb_cnt <= 0;
        else tb_cnt <= tb_cnt + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) begin
            check("rst_sym", int'(sym_out), 0);
            check("rst_strobe", int'(sym_strobe), 0);
            check("rst_start", int'(mod_start), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_level", int'(fifo_level), 0);
            prev_strobe_busy = 1'b0;
        end else begin
            if (sym_strobe) begin
                n_strobe++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("sym", int'(sym_out), int'(e.sym));
                    check("busy_at_strobe", int'(busy), int'(e.busy));
                    check("mod_start_at_strobe", int'(mod_start), int'(e.start));
                    if (prev_strobe_busy) check("strobe_spacing", cyc - last_strobe_cyc, SC);
                end else begin
                    check("unexpected_strobe", int'(sym_strobe), 0);
                end
                prev_strobe_busy = busy;
                last_strobe_cyc = cyc;
            end else begin
                if (sym_out != prev_sym) check("sym_change_without_strobe", int'(sym_strobe), 1);
                if (mod_start) check("start_without_strobe", int'(sym_strobe), 1);
            end
        end
        if (mod_start) begin
            n_start++;
            t_start = cyc;
        end
        prev_sym = sym_out;
    end

    task automatic push_pre();
        for (int k = 0; k < PS; k++) q.push_back('{(k % 2 == 0) ? 2'b11 : 2'b00, 1'b1, (k == 0)});
    endtask

    task automatic push_sym(input logic [1:0] s);
        q.push_back('{s, 1'b1, 1'b0});
    endtask

    task automatic push_data(input logic [7:0] b);
        push_sym(b[7:6]); push_sym(b[5:4]); push_sym(b[3:2]); push_sym(b[1:0]);
    endtask

    task automatic push_idle();
        q.push_back('{2'b00, 1'b0, 1'b0});
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 500 && !u_if.byte_ready; i++) tick();
        check("ready_wait", int'(u_if.byte_ready), 1);
        u_if.byte_in = b;
        u_if.byte_valid = 1'b1;
        tick();
        u_if.byte_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && q.size() != 0; i++) tick();
        check("drain", q.size(), 0);
    endtask

    task automatic bnd_push(input int c, input int lat, input logic [7:0] b);
        int t0, st0;
        for (int i = 0; i < 50 && tb_cnt != c; i++) tick();
        check("phase_found", tb_cnt, c);
        push_pre(); push_data(b); push_idle();
        st0 = n_start;
        t0 = cyc;
        u_if.byte_in = b;
        u_if.byte_valid = 1'b1;
        tick();
        u_if.byte_valid = 1'b0;
        for (int i = 0; i < 100 && n_start == st0; i++) tick();
        check("boundary_start_count", n_start, st0 + 1);
        check("boundary_latency", t_start - t0, lat);
        wait_drain();
    endtask

    vec_t tbl[6];
    logic [7:0] fbytes[6];

    initial begin
        int st0, base, idx;
        logic saw_full;
        tbl[0] = '{8'hB4, {2'b10, 2'b11, 2'b01, 2'b00}};
        tbl[1] = '{8'h1B, {2'b00, 2'b01, 2'b10, 2'b11}};
        tbl[2] = '{8'hE4, {2'b11, 2'b10, 2'b01, 2'b00}};
        tbl[3] = '{8'h00, {2'b00, 2'b00, 2'b00, 2'b00}};
        tbl[4] = '{8'hFF, {2'b11, 2'b11, 2'b11, 2'b11}};
        tbl[5] = '{8'h5A, {2'b01, 2'b01, 2'b10, 2'b10}};
        fbytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};

        reset_n = 1'b0;
        u_if.byte_in = 8'h00;
        u_if.byte_valid = 1'b0;

        // reset and idle
        repeat (20) tick();
        check("ready_in_reset", int'(u_if.byte_ready), 0);
        reset_n = 1'b1;
        #1;
        check("ready_after_release", int'(u_if.byte_ready), 1);
        st0 = n_start;
        base = n_strobe;
        repeat (30) tick();
        check("idle_no_strobe", n_strobe, base);
        check("idle_no_start", n_start, st0);
        check("idle_sym", int'(sym_out), 0);
        check("idle_busy", int'(busy), 0);

        // table: single-byte bursts
        for (int v = 0; v < 6; v++) begin
            st0 = n_start;
            push_pre();
            for (int k = 0; k < 4; k++) push_sym(tbl[v].s[7 - 2 * k -: 2]);
            push_idle();
            push_byte(tbl[v].b);
            wait_drain();
            check("single_start_count", n_start, st0 + 1);
            check("busy_after_burst", int'(busy), 0);
        end

        // back-to-back bytes, second pushed during preamble
        st0 = n_start;
        base = n_strobe;
        push_pre(); push_data(8'h1B);
        push_byte(8'h1B);
        repeat (15) tick();
        push_data(8'hE4);
        push_byte(8'hE4);
        push_idle();
        wait_drain();
        check("b2b_start_count", n_start, st0 + 1);
        check("b2b_strobe_count", n_strobe - base, PS + 8 + 1);

        // FIFO full with valid held high
        st0 = n_start;
        base = n_strobe;
        idx = 0;
        saw_full = 1'b0;
        push_pre();
        for (int t = 0; t < 400 && idx < 6; t++) begin
            u_if.byte_in = fbytes[idx];
            u_if.byte_valid = 1'b1;
            if (idx == 4 && !saw_full) begin
                check("full_ready_low", int'(u_if.byte_ready), 0);
                check("full_level", int'(fifo_level), FD);
                saw_full = 1'b1;
            end
            if (u_if.byte_ready) begin
                if (idx == 4) check("reopen_at_data_entry", n_strobe, base + PS + 1);
                push_data(fbytes[idx]);
                idx++;
            end
            tick();
        end
        u_if.byte_valid = 1'b0;
        check("full_accepts", idx, 6);
        push_idle();
        wait_drain();
        check("full_start_count", n_start, st0 + 1);

        // push on the boundary edge vs one cycle before it
        bnd_push(SC - 1, SC + 1, 8'h3C);
        bnd_push(SC - 2, 2, 8'hC3);

        // mid-burst reset during the 2nd data symbol
        st0 = n_start;
        base = n_strobe;
        push_pre();
        push_sym(2'b10); push_sym(2'b01);
        push_byte(8'h96);
        for (int i = 0; i < 200 && n_strobe < base + PS + 2; i++) tick();
        check("reached_2nd_data", n_strobe, base + PS + 2);
        reset_n = 1'b0;
        #1;
        check("ready_during_reset", int'(u_if.byte_ready), 0);
        tick();
        reset_n = 1'b1;
        check("abort_queue_empty", q.size(), 0);
        check("abort_start_count", n_start, st0 + 1);
        repeat (25) tick();
        check("abort_stays_idle", n_strobe, base + PS + 2);
        st0 = n_start;
        push_pre(); push_data(8'h5A); push_idle();
        push_byte(8'h5A);
        wait_drain();
        check("fresh_start_count", n_start, st0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
